inst_buffer: RTL and testbench

Per-warp instruction buffer between decode and the warp scheduler in the Gelato frontend. It supersedes the single valid+inst entry with a parametrised bank of WARP_NUM independent circular FIFOs, each DEPTH entries of decoded inst_t. It adds per-warp flush for divergence and branch redirect, and exposes per-warp occupancy to fetch and issue.

---
 rtl/inst_buffer_pkg.sv | 20 ++
 rtl/inst_fifo.sv | 51 +++++
 rtl/inst_buffer.sv | 62 ++++++
 tb/tb_inst_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types for the Gelato frontend instruction buffer.
package inst_buffer_pkg;

    // Number of warps in the frontend.
    localparam int GELATO_WARP_NUM = 4;
    // Default entries per warp FIFO; power of two, at least 2.
    localparam int INST_BUF_DEPTH  = 4;

    typedef logic [$clog2(GELATO_WARP_NUM)-1:0] warp_num_t;
    typedef logic [$clog2(INST_BUF_DEPTH):0]    inst_buf_count_t;

    // Decoded instruction as handed from decode to issue.
    typedef struct packed {
        warp_num_t   warp_num;
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [4:0]  rd;
    } inst_t;

endpackage

// File: rtl/inst_fifo.sv
// Single-warp circular FIFO of decoded instructions with synchronous flush.
// The parent gates push/pop so they never fire while this warp is flushed,
// full (push) or empty (pop).
module inst_fifo
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = INST_BUF_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  inst_t         push_data,
    input  logic          pop,
    input  logic          flush,
    output inst_t         head,
    output logic [CW-1:0] count
);

    inst_t         mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointer and occupancy state; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; validity is tracked entirely by count, so
    // clearing the array would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_buffer.sv
// Per-warp instruction buffer between decode and the warp scheduler.
// Routes pushes by push_inst.warp_num, muxes the head selected by sel_warp,
// and applies per-warp flush. No bypass: a push becomes visible next cycle.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int WARP_NUM = GELATO_WARP_NUM,
    parameter int DEPTH    = INST_BUF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_valid,
    input  inst_t               push_inst,
    output logic                push_ready,
    input  warp_num_t           sel_warp,
    output logic                out_valid,
    output inst_t               out_inst,
    input  logic                out_ready,
    input  logic                flush_valid,
    input  warp_num_t           flush_warp,
    output logic [WARP_NUM-1:0] nonempty,
    output logic [WARP_NUM-1:0] has_space
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] counts [WARP_NUM];
    inst_t         heads  [WARP_NUM];
    logic          push_fire;
    logic          pop_fire;

    // A warp being flushed this cycle neither accepts nor offers entries.
    assign push_ready = (counts[push_inst.warp_num] < FULL) &&
                        !(flush_valid && (flush_warp == push_inst.warp_num));
    assign out_valid  = (counts[sel_warp] != '0) &&
                        !(flush_valid && (flush_warp == sel_warp));
    assign out_inst   = heads[sel_warp];

    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = out_valid && out_ready;

    for (genvar w = 0; w < WARP_NUM; w++) begin : g_warp
        inst_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_fire && (push_inst.warp_num == warp_num_t'(w))),
            .push_data (push_inst),
            .pop       (pop_fire && (sel_warp == warp_num_t'(w))),
            .flush     (flush_valid && (flush_warp == warp_num_t'(w))),
            .head      (heads[w]),
            .count     (counts[w])
        );

        // Registered-state decodes only; a flush shows up the cycle after.
        assign nonempty[w]  = (counts[w] != '0);
        assign has_space[w] = (counts[w] != FULL);
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (WARP_NUM=4, DEPTH=4).
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_valid;
    inst_t      push_inst;
    logic       push_ready;
    warp_num_t  sel_warp;
    logic       out_valid;
    inst_t      out_inst;
    logic       out_ready;
    logic       flush_valid;
    warp_num_t  flush_warp;
    logic [3:0] nonempty;
    logic [3:0] has_space;

    int checks   = 0;
    int failures = 0;

    inst_buffer #(.WARP_NUM(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_inst   (push_inst),
        .push_ready  (push_ready),
        .sel_warp    (sel_warp),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .flush_valid (flush_valid),
        .flush_warp  (flush_warp),
        .nonempty    (nonempty),
        .has_space   (has_space)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic inst_t mk(input int w, input logic [31:0] pc);
        inst_t i;
        i.warp_num = warp_num_t'(w);
        i.pc       = pc;
        i.opcode   = pc[9:2] ^ 8'h5a;
        i.rd       = pc[6:2];
        return i;
    endfunction

    task automatic idle();
        push_valid  = 1'b0;
        out_ready   = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic push(input int w, input logic [31:0] pc);
        push_valid = 1'b1;
        push_inst  = mk(w, pc);
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        push_inst  = mk(0, 32'h0);
        sel_warp   = '0;
        flush_warp = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_nonempty", nonempty, 4'h0);
        check("rst_has_space", has_space, 4'hF);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_push_ready", push_ready, 1'b1);

        // Fill warp 2 to DEPTH, then over-push and drain in order.
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_inst  = mk(2, 32'(4 * i));
            #1 check("w2_fill_ready", push_ready, 1'b1);
            tick();
        end
        push_valid = 1'b0;
        #1;
        check("w2_full_has_space", has_space, 4'b1011);
        check("w2_full_nonempty", nonempty, 4'b0100);
        push_valid = 1'b1;
        push_inst  = mk(2, 32'h10);
        #1 check("w2_over_push_ready", push_ready, 1'b0);
        tick();
        push_valid = 1'b0;
        sel_warp   = 2'd2;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("w2_drain_valid", out_valid, 1'b1);
            check("w2_drain_pc", out_inst.pc, 32'(4 * i));
            tick();
        end
        out_ready = 1'b0;
        #1;
        check("w2_empty_valid", out_valid, 1'b0);
        check("w2_empty_nonempty", nonempty, 4'h0);

        // No bypass: push into empty warp 1 shows up one cycle later.
        sel_warp   = 2'd1;
        push_valid = 1'b1;
        push_inst  = mk(1, 32'h100);
        #1 check("w1_same_cycle_valid", out_valid, 1'b0);
        tick();
        push_valid = 1'b0;
        #1;
        check("w1_next_valid", out_valid, 1'b1);
        check("w1_next_pc", out_inst.pc, 32'h100);

        // Warp 0: simultaneous push and pop with two entries held.
        push(0, 32'h200);
        push(0, 32'h204);
        sel_warp   = 2'd0;
        out_ready  = 1'b1;
        push_valid = 1'b1;
        push_inst  = mk(0, 32'h208);
        #1;
        check("w0_pp_ready", push_ready, 1'b1);
        check("w0_pp_valid", out_valid, 1'b1);
        check("w0_pp_pc", out_inst.pc, 32'h200);
        tick();
        idle();
        #1;
        check("w0_pp_head", out_inst.pc, 32'h204);
        check("w0_pp_nonempty", nonempty, 4'b0011);
        check("w0_pp_has_space", has_space, 4'hF);
        push(0, 32'h20C);
        push(0, 32'h210);
        #1 check("w0_full_has_space", has_space, 4'b1110);
        // Full warp with a pop this cycle still refuses the push.
        out_ready  = 1'b1;
        push_valid = 1'b1;
        push_inst  = mk(0, 32'h214);
        #1;
        check("w0_full_pop_ready", push_ready, 1'b0);
        check("w0_full_pop_valid", out_valid, 1'b1);
        check("w0_full_pop_pc", out_inst.pc, 32'h204);
        tick();
        push_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("w0_drain_pc", out_inst.pc, 32'h208 + 32'(4 * i));
            tick();
        end
        out_ready = 1'b0;
        #1 check("w0_drained", nonempty, 4'b0010);

        // Flush warp 3 while pushing and popping it; warp 1 must be untouched.
        push(3, 32'h300);
        push(3, 32'h304);
        push(3, 32'h308);
        #1 check("w3_loaded", nonempty, 4'b1010);
        sel_warp    = 2'd3;
        out_ready   = 1'b1;
        push_valid  = 1'b1;
        push_inst   = mk(3, 32'h30C);
        flush_valid = 1'b1;
        flush_warp  = 2'd3;
        #1;
        check("w3_flush_push_ready", push_ready, 1'b0);
        check("w3_flush_out_valid", out_valid, 1'b0);
        check("w3_flush_same_cycle_nonempty", nonempty, 4'b1010);
        tick();
        idle();
        #1;
        check("w3_flushed_nonempty", nonempty, 4'b0010);
        check("w3_flushed_has_space", has_space, 4'hF);
        sel_warp = 2'd1;
        #1;
        check("w1_untouched_valid", out_valid, 1'b1);
        check("w1_untouched_pc", out_inst.pc, 32'h100);
        check("w1_untouched_op", out_inst.opcode, 8'h40 ^ 8'h5a);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Stream 10 instructions through warp 0 so both pointers wrap.
        sel_warp  = 2'd0;
        out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            push_valid = (c < 10);
            push_inst  = mk(0, 32'h400 + 32'(4 * c));
            #1;
            if (c == 0) begin
                check("wrap_first_valid", out_valid, 1'b0);
            end else begin
                check("wrap_valid", out_valid, 1'b1);
                check("wrap_pc", out_inst.pc, 32'h400 + 32'(4 * (c - 1)));
            end
            tick();
        end
        idle();
        #1 check("wrap_empty", nonempty, 4'h0);

        // Reset mid-operation with warps 0 and 2 partially full.
        push(0, 32'h500);
        push(0, 32'h504);
        push(2, 32'h600);
        #1 check("pre_rst_nonempty", nonempty, 4'b0101);
        rst        = 1'b1;
        push_valid = 1'b1;
        push_inst  = mk(2, 32'h604);
        sel_warp   = 2'd0;
        out_ready  = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("mid_rst_nonempty", nonempty, 4'h0);
        check("mid_rst_has_space", has_space, 4'hF);
        check("mid_rst_out_valid0", out_valid, 1'b0);
        sel_warp = 2'd2;
        #1 check("mid_rst_out_valid2", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
